regbank_sb: RTL

- Parametrised successor to the single-write register bank, for the pipelined datapath's decode/writeback stages.
- Provides N read ports, two write ports with fixed priority, and register 0 hardwired to zero.
- Adds a per-register busy scoreboard for hazard detection and a sequential clear engine for reset and pipeline flush.

---
 rtl/regbank_pkg.sv | 24 ++
 rtl/regbank_scoreboard.sv | 70 +++++++
 rtl/regbank_sb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared definitions for the regbank_sb register bank:
//   - state_e      : clear-engine state encoding (ST_CLEAR, ST_RUN)
//   - DEF_DATA_W   : default register width
//   - DEF_ADDR_W   : default register address width
//   - port_lsb()   : LSB of a read port's slice in a flattened port bus
// -----------------------------------------------------------------------------
package regbank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Read port i occupies bits [port_lsb(i, W) +: W] of a flattened bus.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// -----------------------------------------------------------------------------
// regbank_scoreboard
// Per-register busy bits used for hazard detection.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears all bits)
//   flush             : clears all busy bits at the next edge
//   upd_en            : allows writes/allocs to update the bits (RUN, no flush)
//   we0/wa0, we1/wa1  : write ports; a write clears busy[addr]
//   alloc_en/addr     : marks a register busy; wins over a same-cycle write
//   ra                : flattened read addresses (NRD x ADDR_W)
//   rbusy             : stored busy bit of each read address
// Register 0 is never busy.
// -----------------------------------------------------------------------------
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  upd_en,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD-1:0]        rbusy
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_d[i] = busy_q[i];
      if (i == 0) begin
        busy_d[i] = 1'b0;
      end else if (flush) begin
        busy_d[i] = 1'b0;
      end else if (upd_en) begin
        if ((we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i))) begin
          busy_d[i] = 1'b0;
        end
        // Applied after the clear: a newer producer is still pending.
        if (alloc_en && alloc_addr == ADDR_W'(i)) begin
          busy_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rbusy
    assign rbusy[gi] = busy_q[ra[port_lsb(gi, ADDR_W) +: ADDR_W]];
  end

endmodule

// File: rtl/regbank_sb.sv
// -----------------------------------------------------------------------------
// regbank_sb
// Multi-port register bank with busy scoreboard and sequential clear engine.
// Register 0 reads as zero and ignores writes; write port 1 beats port 0 on
// an address collision. After reset or flush the bank spends NUM_REGS cycles
// zeroing one register per cycle (ready low) before entering RUN.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : one-cycle pulse, restarts the clear sequence
//   ready                 : high in RUN
//   we0/wa0/wd0           : write port 0
//   we1/wa1/wd1           : write port 1 (priority)
//   ra / rd / rbusy       : NRD flattened asynchronous read ports
//   alloc_en / alloc_addr : mark a destination register busy
// Configuration macro:
//   REGBANK_BYPASS_EN     : when defined, reads forward same-cycle write data
//                           and report not-busy for the forwarded register.
// -----------------------------------------------------------------------------
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  ready,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];

  logic               run;
  logic               upd_en;
  logic               w0_act;
  logic               w1_act;
  logic [NRD-1:0]     sb_rbusy;

  assign run    = (state_q == ST_RUN);
  assign ready  = run;
  // A flush in RUN drops every write and alloc of that cycle.
  assign upd_en = run && !flush;
  assign w0_act = upd_en && we0 && (wa0 != '0);
  assign w1_act = upd_en && we1 && (wa1 != '0);

  // Clear engine
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage: the clear engine owns the write path while not in RUN.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i == 0) begin
        regs_d[i] = '0;
      end else if (!run) begin
        if (cnt_q[ADDR_W-1:0] == ADDR_W'(i)) begin
          regs_d[i] = '0;
        end
      end else if (w1_act && wa1 == ADDR_W'(i)) begin
        regs_d[i] = wd1;
      end else if (w0_act && wa0 == ADDR_W'(i)) begin
        regs_d[i] = wd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  regbank_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .upd_en     (upd_en),
    .we0        (we0 && (wa0 != '0)),
    .wa0        (wa0),
    .we1        (we1 && (wa1 != '0)),
    .wa1        (wa1),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .ra         (ra),
    .rbusy      (sb_rbusy)
  );

  // Read ports
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = ra[port_lsb(gi, ADDR_W) +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      busy = sb_rbusy[gi];
`ifdef REGBANK_BYPASS_EN
      // Port 1 checked first so it wins when both ports hit this address.
      if (w1_act && wa1 == addr) begin
        data = wd1;
        busy = 1'b0;
      end else if (w0_act && wa0 == addr) begin
        data = wd0;
        busy = 1'b0;
      end
`endif
      if (addr == '0) begin
        data = '0;
      end
      if (!run) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd[port_lsb(gi, DATA_W) +: DATA_W] = data;
    assign rbusy[gi] = busy;
  end

endmodule
